seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Keeps the five existing operation encodings: ADD, SUB, AND, OR, SLT.
- Adds shifts, unsigned compare, and an iterative shift-add multiply.
- Adds status flags and valid/ready handshakes on both sides, so the datapath can stall on multi-cycle operations.

Parameters:
- WIDTH, 32: operand and result width in bits. Minimum 8, power of two.
- SHAMT_W, $clog2(WIDTH): number of operand2 LSBs used as the shift amount.

Ports:
- clk, input, 1: system clock. All state changes on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: request present on operand1/operand2/opCode.
- in_ready, output, 1: block can accept a request.
- operand1, input, WIDTH: first operand, two's complement.
- operand2, input, WIDTH: second operand, or shift amount source.
- opCode, input, 6: operation select.
- out_valid, output, 1: result and flags valid.
- out_ready, input, 1: consumer takes the result.
- result, output, WIDTH: operation result.
- zero, output, 1: result == 0.
- overflow, output, 1: signed overflow (ADD/SUB only).
- illegal, output, 1: opCode not in the supported set.

Behaviour:
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR.
  - 4 SLT: signed; result = {0…, (op1 < op2)} computed as a true signed compare, not the sign of the difference, so it is correct on overflow.
  - 5 SLL; 6 SRL; 7 SRA: shift operand1 by operand2[SHAMT_W-1:0].
  - 8 MUL: low WIDTH bits of op1*op2.
  - 9 SLTU: unsigned compare.
  - Others: illegal. Result 0, illegal=1, zero=1, overflow=0.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE). out_valid = (state==DONE).
  - Accept occurs when in_valid && in_ready. Operands and opCode are latched on accept; input changes afterwards are ignored.
  - IDLE, accept of a non-MUL op (including illegal): result and flags registered on the same edge; go to DONE. out_valid is high on the cycle after accept (latency 1).
  - IDLE, accept of MUL: clear accumulator, load multiplicand/multiplier, count = 0; go to MUL.
  - MUL: each cycle, if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. After the WIDTH-th iteration, register result/flags and go to DONE. out_valid rises WIDTH+1 cycles after accept. No early termination, so latency is fixed.
  - DONE: hold result/flags stable while out_ready=0. On out_ready=1, go to IDLE on that edge. No new request is accepted in the same cycle; the next accept is possible one cycle later. Throughput is at most one op per 2 cycles.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = signed overflow: operands share a sign (ADD) or differ in sign (SUB), and the result sign differs from operand1.
  - overflow = 0 for all other ops.
  - Shift amount uses only the low SHAMT_W bits; upper operand2 bits are ignored. Shift by 0 returns operand1 unchanged.
  - SRA sign-fills; SRL zero-fills.
  - zero is computed from the final registered result.
- Reset:
  - rst=1 forces state=IDLE and clears result, zero, overflow, illegal, the accumulator and the counter.
  - out_valid=0; in_ready=1 in the first cycle after reset deasserts.
  - Reset during MUL or DONE aborts the operation; the result is discarded and not presented.
  - rst takes priority over in_valid/out_ready in the same cycle.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid the next cycle; result 0x80000000, overflow=1, zero=0.
- SUB 5 - 5, then SLT 0x80000000 vs 0x00000001, then SLTU with the same operands -> results 0 (zero=1), 1, 0.
- SRA 0xF0000000 by operand2=0x00000024 (effective shift 4) -> 0xFF000000; SRL -> 0x0F000000; SLL 0x1 by 31 -> 0x80000000.
- MUL 0xFFFFFFFD * 0x00000007 -> out_valid exactly 33 cycles after accept; result 0xFFFFFFEB (-21); in_ready low throughout.
- Backpressure: hold out_ready=0 for 10 cycles after an OR, toggling the inputs -> result/flags stable, in_ready=0, no second accept; releasing out_ready returns to IDLE, and the next accept occurs 1 cycle later.
- Assert rst mid-MUL (cycle 12), and separately send opCode 0x3F -> after reset no out_valid and all outputs 0; the illegal op returns result 0, illegal=1, zero=1.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift/compare ops and a
// fixed-latency iterative shift-add multiply, with zero/overflow/illegal flags.
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [5:0]       opCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_SLT  = 6'd4;
    localparam logic [5:0] OP_SLL  = 6'd5;
    localparam logic [5:0] OP_SRL  = 6'd6;
    localparam logic [5:0] OP_SRA  = 6'd7;
    localparam logic [5:0] OP_MUL  = 6'd8;
    localparam logic [5:0] OP_SLTU = 6'd9;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHAMT_W-1:0] count_q, count_d;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_ovf;
    logic               alu_illegal;
    logic [WIDTH-1:0]   mul_sum;

    assign shamt   = operand2[SHAMT_W-1:0];
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle datapath, evaluated straight from the request inputs.
    always_comb begin
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (opCode)
            OP_ADD: begin
                alu_result = operand1 + operand2;
                alu_ovf    = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = operand1 - operand2;
                alu_ovf    = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND:  alu_result = operand1 & operand2;
            OP_OR:   alu_result = operand1 | operand2;
            OP_SLT:  alu_result[0] = $signed(operand1) < $signed(operand2);
            OP_SLL:  alu_result = operand1 << shamt;
            OP_SRL:  alu_result = operand1 >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(operand1) >>> shamt);
            OP_MUL:  alu_result = '0;
            OP_SLTU: alu_result[0] = operand1 < operand2;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (opCode == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = operand1;
                        mplier_d = operand2;
                        count_d  = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d  = alu_result;
                        zero_d    = (alu_result == '0);
                        ovf_d     = alu_ovf;
                        illegal_d = alu_illegal;
                        state_d   = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + SHAMT_W'(1);
                // Always WIDTH iterations so the latency never depends on the data.
                if (count_q == SHAMT_W'(WIDTH - 1)) begin
                    result_d  = mul_sum;
                    zero_d    = (mul_sum == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, backpressure and reset corner
// sequences, then random operations scored against an arithmetic reference.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [5:0]   opCode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int n_vec = 0;
    int n_err = 0;
    logic [W+2:0] exp_q[$];

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic       z;
        logic       o;
        logic       il;
        int         hold;
    } vec_t;

    vec_t tbl[17];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .opCode(opCode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".out_valid"}, out_valid, 1'b0);
        check({name, ".in_ready"}, in_ready, 1'b1);
        check({name, ".result"}, result, '0);
        check({name, ".flags"}, {zero, overflow, illegal}, 3'b000);
    endtask

    // Reference model from the arithmetic definitions of each opcode.
    function automatic logic [W+2:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, ua, ub, wide, d;
        logic [W-1:0] r;
        logic o, il;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        sh = int'(b[4:0]);
        d  = longint'(1) << sh;
        r  = '0;
        o  = 1'b0;
        il = 1'b0;
        case (op)
            6'd0: begin
                wide = sa + sb;
                r = wide[31:0];
                o = (wide >= 64'sd2147483648) || (wide < -64'sd2147483648);
            end
            6'd1: begin
                wide = sa - sb;
                r = wide[31:0];
                o = (wide >= 64'sd2147483648) || (wide < -64'sd2147483648);
            end
            6'd2: r = a & b;
            6'd3: r = a | b;
            6'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            6'd5: begin wide = ua * d; r = wide[31:0]; end
            6'd6: begin wide = ua / d; r = wide[31:0]; end
            6'd7: begin
                wide = (sa >= 0) ? (sa / d) : -((-sa + d - 1) / d);
                r = wide[31:0];
            end
            6'd8: begin wide = ua * ub; r = wide[31:0]; end
            6'd9: r = (ua < ub) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
        return {il, o, (r == '0), r};
    endfunction

    // ---------------- driver ----------------
    // Called and returns on a negedge. hold > 0 keeps out_ready low that many
    // cycles after the result appears, with fresh requests on the inputs.
    task automatic send(input string name, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W+2:0] exp, input int hold);
        int lat;
        logic rdy_seen;
        logic stable;
        logic [W+2:0] e;
        exp_q.push_back(exp);
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        check({name, ".ready"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        opCode    = op;
        operand1  = a;
        operand2  = b;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        opCode   = 6'($urandom_range(0, 9));
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check({name, ".result"}, result, e[W-1:0]);
        check({name, ".zero"}, zero, e[W]);
        check({name, ".overflow"}, overflow, e[W+1]);
        check({name, ".illegal"}, illegal, e[W+2]);
        check({name, ".latency"}, lat, (op == 6'd8) ? W + 1 : 1);
        check({name, ".busy"}, rdy_seen, 1'b0);
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                opCode   = 6'($urandom_range(0, 9));
                operand1 = $urandom;
                operand2 = $urandom;
                @(negedge clk);
                if (!out_valid || in_ready || {illegal, overflow, zero, result} !== e)
                    stable = 1'b0;
            end
            check({name, ".hold_stable"}, stable, 1'b1);
            opCode    = 6'd0;
            out_ready = 1'b1;
            @(negedge clk);
            check({name, ".release_idle"}, {out_valid, in_ready}, 2'b01);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [5:0]   op;
        logic [W-1:0] a, b;
        logic         seen;

        tbl[0]  = '{"add_ovf",   6'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{"sub_zero",  6'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{"slt_neg",   6'd4,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{"sltu",      6'd9,  32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{"sra",       6'd7,  32'hF0000000, 32'h00000024, 32'hFF000000, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{"srl",       6'd6,  32'hF0000000, 32'h00000024, 32'h0F000000, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{"sll31",     6'd5,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{"mul_neg",   6'd8,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{"illegal",   6'h3F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1, 0};
        tbl[9]  = '{"and",       6'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{"or_hold",   6'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 10};
        tbl[11] = '{"sub_ovf",   6'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{"sll_zero",  6'd5,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{"add_wrap",  6'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};
        tbl[14] = '{"slt_ovf",   6'd4,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};
        tbl[15] = '{"sra31",     6'd7,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0};
        tbl[16] = '{"mul_zero",  6'd8,  32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        operand1 = '0;
        operand2 = '0;
        opCode = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        foreach (tbl[i])
            send(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b,
                 {tbl[i].il, tbl[i].o, tbl[i].z, tbl[i].r}, tbl[i].hold);

        // Reset in the middle of a multiply, with a competing request on the inputs.
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        in_valid = 1'b1;
        opCode   = 6'd8;
        operand1 = 32'h0000FFFF;
        operand2 = 32'h00010001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        opCode = 6'd0;
        operand1 = 32'h1;
        operand2 = 32'h2;
        @(negedge clk);
        check_reset_outputs("rst_mid_mul");
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst_mul");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_discard", seen, 1'b0);

        // Random operations scored against the reference model.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            op  = (sel <= 9) ? 6'(sel) : 6'($urandom_range(10, 63));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            send($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b), 0);
        end

        check("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
